// File: rtl/core_types_pkg.sv
// core_types_pkg: shared control packet and state types for the memory stage
package core_types_pkg;
  typedef enum logic [1:0] {MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10} mem_size_t;
  typedef struct packed {
    logic      mem_en;
    logic      we;
    mem_size_t size;
    logic      is_unsigned;
  } dmem_req_ctrl_t;
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } rf_wb_ctrl_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
endpackage

// File: rtl/dl_reg_en_rst.sv
// dl_reg_en_rst: enabled pipeline register with asynchronous active-low reset to zero
module dl_reg_en_rst #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_load_align.sv
// mem_load_align: extracts a byte/half/word from a raw read word and sign/zero-extends it
module mem_load_align
  import core_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = rdata >> {offset, 3'b000};
  assign data = size == MEM_B ? {{24{~is_unsigned & sh[7]}}, sh[7:0]} :
                size == MEM_H ? {{16{~is_unsigned & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage driving a valid/ready dmem request and valid-only response.
// MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses; otherwise addresses are forced aligned.
module mem_stage
  import core_types_pkg::*;
#(parameter int N_BITS = 32) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_BITS-1:0]                  X_out_in,
  input  logic [N_BITS-1:0]                  store_data_in,
  input  logic [$bits(dmem_req_ctrl_t)-1:0]  dmem_req_ctrl_pkt_in,
  input  logic [$bits(rf_wb_ctrl_t)-1:0]     rf_wb_ctrl_pkt_in,
  output logic                               dmem_req_valid,
  input  logic                               dmem_req_ready,
  output logic [N_BITS-1:0]                  dmem_req_addr,
  output logic                               dmem_req_we,
  output logic [3:0]                         dmem_req_be,
  output logic [N_BITS-1:0]                  dmem_req_wdata,
  input  logic                               dmem_resp_valid,
  input  logic [N_BITS-1:0]                  dmem_resp_rdata,
  output logic                               M_stall,
  output logic                               M_misalign,
  output logic [$bits(rf_wb_ctrl_t)-1:0]     rf_wb_ctrl_pkt_out,
  output logic [N_BITS-1:0]                  M_out
);
  logic [N_BITS-1:0] x_q, sd_q, ld;
  logic [$bits(dmem_req_ctrl_t)-1:0] ctl_v;
  logic [$bits(rf_wb_ctrl_t)-1:0] wb_v;
  dmem_req_ctrl_t ctl_q;
  rf_wb_ctrl_t wb_q, wb_o;
  mem_state_t state, nxt;
  logic [1:0] a;
  logic act;
  dl_reg_en_rst #(.W(N_BITS)) u_x (.clk(clk), .rst_n(rst_n), .en(~M_stall), .d(X_out_in), .q(x_q));
  dl_reg_en_rst #(.W(N_BITS)) u_sd (.clk(clk), .rst_n(rst_n), .en(~M_stall), .d(store_data_in), .q(sd_q));
  dl_reg_en_rst #(.W($bits(dmem_req_ctrl_t))) u_ctl (.clk(clk), .rst_n(rst_n), .en(~M_stall), .d(dmem_req_ctrl_pkt_in), .q(ctl_v));
  dl_reg_en_rst #(.W($bits(rf_wb_ctrl_t))) u_wb (.clk(clk), .rst_n(rst_n), .en(~M_stall), .d(rf_wb_ctrl_pkt_in), .q(wb_v));
  assign ctl_q = dmem_req_ctrl_t'(ctl_v);
  assign wb_q = rf_wb_ctrl_t'(wb_v);
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis = ctl_q.mem_en && ((ctl_q.size == MEM_H && x_q[0]) || (ctl_q.size == MEM_W && x_q[1:0] != 2'b00));
  assign a = x_q[1:0];
  assign dmem_req_addr = x_q;
  assign M_misalign = mis && state == IDLE;
  assign act = ctl_q.mem_en && !mis;
`else
  assign a = ctl_q.size == MEM_W ? 2'b00 : ctl_q.size == MEM_H ? {x_q[1], 1'b0} : x_q[1:0];
  assign dmem_req_addr = {x_q[N_BITS-1:2], a};
  assign M_misalign = 1'b0;
  assign act = ctl_q.mem_en;
`endif
  assign dmem_req_we = ctl_q.we;
  assign dmem_req_be = ctl_q.size == MEM_B ? 4'b0001 << a :
                       ctl_q.size == MEM_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  assign dmem_req_wdata = ctl_q.size == MEM_B ? {4{sd_q[7:0]}} :
                          ctl_q.size == MEM_H ? {2{sd_q[15:0]}} : sd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // A store retires in its handshake cycle; a load always waits in RESP for its data.
  always_comb begin
    nxt = state;
    dmem_req_valid = 1'b0;
    M_stall = 1'b0;
    case (state)
      IDLE, REQ: if (state == REQ || act) begin
        dmem_req_valid = 1'b1;
        nxt = dmem_req_ready ? (ctl_q.we ? IDLE : RESP) : REQ;
        M_stall = !(dmem_req_ready && ctl_q.we);
      end
      RESP: begin
        M_stall = !dmem_resp_valid;
        nxt = dmem_resp_valid ? IDLE : RESP;
      end
      default: nxt = IDLE;
    endcase
  end
  mem_load_align u_align (.rdata(dmem_resp_rdata), .offset(a), .size(ctl_q.size), .is_unsigned(ctl_q.is_unsigned), .data(ld));
  assign M_out = state == RESP ? ld : x_q;
  always_comb begin
    wb_o = wb_q;
    wb_o.we = wb_q.we && !M_stall && !M_misalign;
  end
  assign rf_wb_ctrl_pkt_out = wb_o;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the execute stage.
- Registers the execute result (ALU output / effective address), store data and the control packets.
- Issues data-memory requests over a valid/ready request channel and a valid-only response channel, with byte-lane alignment on stores and extraction plus extension on loads.
- Produces the write-back value and write-back control for the following stage, and stalls upstream while a memory transaction is outstanding.

Parameters:
N_BITS, 32, datapath width; byte-lane logic is fixed at 4 lanes, so only 32 is supported.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
X_out_in  in  N_BITS  execute result; the memory address for loads/stores
store_data_in  in  N_BITS  rs2 value for stores
dmem_req_ctrl_pkt_in  in  $bits(dmem_req_ctrl_t)  mem_en, we, size, is_unsigned
rf_wb_ctrl_pkt_in  in  $bits(rf_wb_ctrl_t)  write-back control (rd, we)
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_addr  out  N_BITS  request address
dmem_req_we  out  1  1 = store
dmem_req_be  out  4  byte enables
dmem_req_wdata  out  N_BITS  lane-replicated store data
dmem_resp_valid  in  1  load data valid
dmem_resp_rdata  in  N_BITS  raw word read data
M_stall  out  1  upstream must hold its registers
M_misalign  out  1  misaligned access flag
rf_wb_ctrl_pkt_out  out  $bits(rf_wb_ctrl_t)  write-back control; we gated
M_out  out  N_BITS  write-back data

Behaviour:
- Pipeline registers (X_out, store data, both packets) use asynchronous reset to 0 and en = ~M_stall.
- Reset values:
  - FSM in IDLE.
  - dmem_req_valid = 0, M_stall = 0, M_misalign = 0.
  - M_out = 0; rf_wb_ctrl_pkt_out = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If the registered mem_en = 1 and the access is not trapped as misaligned, assert dmem_req_valid combinationally.
  - Handshake in the same cycle: a store completes (M_stall = 0, stay IDLE); a load goes to RESP with M_stall = 1.
  - No handshake: go to REQ with M_stall = 1.
  - If mem_en = 0: M_stall = 0 and M_out = X_out register.
- REQ:
  - dmem_req_valid = 1; addr, we, be and wdata are held stable, since they derive from stalled registers.
  - On ready, a store goes to IDLE with M_stall low that cycle; a load goes to RESP.
- RESP:
  - dmem_req_valid = 0 and M_stall = 1 until dmem_resp_valid.
  - In the resp_valid cycle: M_stall = 0, M_out = aligned load data, next state IDLE.
- Minimum load latency is 2 cycles from capture. dmem_resp_valid is ignored in IDLE and REQ.
- Write-back gating: rf_wb_ctrl_pkt_out equals the registered packet, with we forced to 0 whenever M_stall = 1 or M_misalign = 1.
- Store lanes, with a = addr[1:0]:
  - B: be = 4'b0001 << a; wdata = {4{data[7:0]}}.
  - H: be = 4'b0011 << (2*a[1]); wdata = {2{data[15:0]}}.
  - W: be = 4'b1111; wdata = data.
- Loads: shift rdata right by 8*a, take 8/16/32 bits, then sign-extend, or zero-extend when is_unsigned.
- dmem_req_addr = X_out register (low bits per the optional feature).
- Reset mid-transaction: the FSM returns to IDLE and dmem_req_valid drops immediately. A stale response after reset is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: an H access with addr[0] = 1, or a W access with addr[1:0] != 0, issues no request and does not stall. M_misalign = 1 for that instruction's single cycle, and write-back is suppressed.
- Undefined: no trap. The address is forced aligned (H clears bit 0, W clears bits [1:0]) for both request and extraction, and M_misalign is tied 0.

Decomposition:
- core_types_pkg:
  - mem_size_t enum (MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10).
  - dmem_req_ctrl_t fields mem_en, we, size, is_unsigned.
  - mem_state_t (IDLE/REQ/RESP).
- Pipeline registers reuse dl_reg_en_rst.
- One combinational sub-module, mem_load_align (rdata, offset, size, is_unsigned -> extended data).

Test Plan:
- ALU op, X_out_in = 0x0000_1234, mem_en = 0 -> next cycle M_out = 0x1234, write-back we passes, M_stall = 0, no request.
- Store SB, addr 0x103, data 0xAABBCCDD, ready = 1 immediately -> be = 4'b1000, wdata = 0xDDDDDDDD, single cycle, M_stall never high.
- Load LB, addr 0x102, ready delayed 2 cycles, resp 3 cycles later with rdata 0x0080FF00 -> M_stall high 5 cycles, M_out = 0xFFFFFF80. Repeated as LBU -> M_out = 0x00000080.
- Load LH addr 0x2, rdata 0x8001_0000 -> M_out = 0xFFFF8001. Stray resp_valid asserted while in REQ -> ignored.
- Load LW addr 0x6 -> with macro: M_misalign = 1 for 1 cycle, no dmem_req_valid, we = 0. Without macro: dmem_req_addr = 0x4, normal load.
- rst_n asserted while in RESP -> dmem_req_valid/M_stall drop asynchronously. A later resp_valid is ignored and the next op works normally.
